depth_frame_writer: RTL and testbench
=====================================

Name: depth_frame_writer

Overview:
Sink end of the depth-map pixel stream. Consumes the VSYNC/HSYNC-framed 2-pixel beats produced by the disparity image reader and tracks row/column position. Buffers beats in a small FIFO and writes them as packed pixel pairs through a simple write port to the frame store. Signals frame completion, FIFO overflow and aborted frames.

Parameters:
WIDTH, 320, image width in pixels; must be even.
HEIGHT, 240, image height in lines.
DW, 8, bits per pixel.
ADDR_W, 16, pair-address width; 2^ADDR_W >= WIDTH*HEIGHT/2.
FIFO_DEPTH, 8, beat FIFO entries; power of two.

Ports:
HCLK  in  1  clock; all logic on rising edge.
HRESET  in  1  reset, synchronous, active-high.
VSYNC  in  1  high during vertical blanking; a high level arms a new frame.
HSYNC  in  1  beat strobe; one pixel pair is valid in each cycle it is high.
DATA_0  in  DW  even pixel (col).
DATA_1  in  DW  odd pixel (col+1).
mem_we  out  1  write request; equals FIFO not-empty.
mem_addr  out  ADDR_W  pair address = row*WIDTH/2 + col/2.
mem_wdata  out  2*DW  {DATA_1, DATA_0}.
mem_ready  in  1  write accepted when mem_we & mem_ready.
write_done  out  1  level; the frame is fully written.
overflow  out  1  sticky; one or more beats were dropped.
frame_abort  out  1  sticky; VSYNC arrived mid-frame.
frame_cnt  out  8  count of completed frames; wraps at 255.

Behaviour:
- Reset (HRESET=1 at an edge):
  - State goes to ST_IDLE; FIFO is emptied; row, col and pair counter are set to 0.
  - mem_we=0, mem_addr=0, mem_wdata=0, write_done=0, overflow=0, frame_abort=0, frame_cnt=0.
  - Reset overrides every other event in the same cycle.
- State machine:
  - ST_IDLE: VSYNC=1 -> ST_ARMED.
  - ST_ARMED: clears row, col and pair counter each cycle. VSYNC=0 -> ST_FRAME.
  - ST_FRAME: VSYNC=1 -> ST_ARMED; flush FIFO, set frame_abort. Otherwise, after the beat that completes WIDTH*HEIGHT/2 pairs -> ST_DRAIN.
  - ST_DRAIN: VSYNC=1 -> ST_ARMED; flush FIFO, set frame_abort. FIFO empty -> ST_DONE; in the same edge, write_done<=1 and frame_cnt+1.
  - ST_DONE: write_done held at 1. VSYNC=1 -> ST_ARMED; write_done<=0. Sticky flags clear only on reset.
- Beat capture (ST_FRAME only):
  - An HSYNC=1 cycle pushes {addr, DATA_1, DATA_0} at that edge.
  - Position update: col+=2; at col==WIDTH-2, col<=0 and row+=1.
  - The address is kept by an incrementing pair counter; no multiplier.
  - HSYNC in any other state is ignored. HSYNC and VSYNC high together in ST_FRAME: VSYNC wins and the beat is discarded.
- FIFO:
  - mem_we/mem_addr/mem_wdata are driven from the head entry (registered storage).
  - pop = mem_we & mem_ready.
  - Latency: with mem_ready=1, a beat sampled at edge t appears on mem_we at cycle t+1. This sustains 1 write per cycle.
  - Full with a pop in the same cycle: the push is accepted.
  - Full with no pop: the beat is dropped and overflow<=1. col/row and the pair counter still advance, so the frame geometry stays aligned.
  - Outputs hold stable while mem_we=1 and mem_ready=0.
  - When empty, mem_addr and mem_wdata hold their last values.
- Width rules: pixels are stored unmodified, no arithmetic on data; the pair counter is ADDR_W bits; frame_cnt wraps modulo 256.

Decomposition:
- Package depth_pkg holds the state encoding (ST_IDLE, ST_ARMED, ST_FRAME, ST_DRAIN, ST_DONE), the default WIDTH/HEIGHT/DW, and PAIRS_PER_FRAME = WIDTH*HEIGHT/2.
- One sub-module, pair_fifo: synchronous FIFO with parameters FIFO_DEPTH and data width ADDR_W+2*DW. It has push/pop/flush inputs and full/empty outputs, and takes the same clock and reset.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=2 (8 pairs) and ADDR_W=16.
1. Clean frame: VSYNC high 3 cycles, then 8 HSYNC beats with DATA_0=2k, DATA_1=2k+1, mem_ready=1 -> 8 writes to addr 0..7, wdata 0x0100, 0x0302 … 0x0F0E; write_done=1 one cycle after the last write; frame_cnt=1; no flags set.
2. Backpressure: FIFO_DEPTH=8, mem_ready=0 during all 8 beats, then 1 -> no drops, 8 in-order writes, overflow=0.
3. Overflow: FIFO_DEPTH=4, mem_ready=0 through beats 0-5 -> beats 4 and 5 dropped, overflow=1. Writes addr 0,1,2,3,6,7; write_done still asserts.
4. Abort: VSYNC pulses after beat 3 -> frame_abort=1, no further writes of the old frame; a full clean frame follows with addr restarting at 0 and frame_cnt=1.
5. Reset mid-frame: HRESET high for 1 cycle after beat 2 -> the next edge shows mem_we=0 and write_done=0; HSYNC ignored until VSYNC; a subsequent clean frame passes.
6. Stray beats: HSYNC in ST_IDLE and ST_DONE -> no mem_we, no counter change; a second clean frame gives frame_cnt=2.

Source files
------------

// File: rtl/depth_pkg.sv
// Shared definitions for the depth-map frame writer: state encoding,
// default geometry and the pair-count helper.
package depth_pkg;

  localparam int WIDTH_DEF      = 320;
  localparam int HEIGHT_DEF     = 240;
  localparam int DW_DEF         = 8;
  localparam int ADDR_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  // Pixel pairs in one frame at the default geometry
  localparam int PAIRS_PER_FRAME = WIDTH_DEF * HEIGHT_DEF / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FRAME = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pixel pairs in a frame of arbitrary geometry (width must be even)
  function automatic int pairs_per_frame(input int w, input int h);
    return w * h / 2;
  endfunction

endpackage

// File: rtl/depth_frame_writer_if.sv
// Frame-store write port: one packed pixel pair per accepted request.
interface depth_frame_writer_if
  import depth_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DW     = DW_DEF
);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2*DW-1:0]   mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);

endinterface

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding {address, pixel pair} entries. The read
// side shows the head entry combinationally from registered storage and,
// once empty, keeps presenting the most recently popped entry.
module pair_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] last_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush empties the FIFO
  always_ff @(posedge HCLK) begin
    if (HRESET || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge HCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Remember the last entry handed out so the outputs hold once empty
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_q <= '0;
    end else if (do_pop) begin
      last_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/depth_frame_writer.sv
// Sink for the VSYNC/HSYNC framed depth-map stream. Tracks frame position,
// queues 2-pixel beats and writes them as packed pairs to the frame store,
// reporting completion, dropped beats and aborted frames.
module depth_frame_writer
  import depth_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int DW         = DW_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 VSYNC,
  input  logic                 HSYNC,
  input  logic [DW-1:0]        DATA_0,
  input  logic [DW-1:0]        DATA_1,
  depth_frame_writer_if.master mem,
  output logic                 write_done,
  output logic                 overflow,
  output logic                 frame_abort,
  output logic [7:0]           frame_cnt
);

  localparam int PAIRS   = pairs_per_frame(WIDTH, HEIGHT);
  localparam int ENTRY_W = ADDR_W + 2*DW;
  localparam int COL_W   = $clog2(WIDTH);
  localparam int ROW_W   = $clog2(HEIGHT + 1);

  state_t             state_q;
  state_t             state_d;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [ADDR_W-1:0]  pair_q;

  logic               beat;
  logic               last_beat;
  logic               abort_ev;
  logic               done_ev;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  // A beat counts only while receiving; VSYNC in the same cycle discards it
  assign beat      = (state_q == ST_FRAME) & HSYNC & ~VSYNC;
  assign last_beat = beat & (pair_q == ADDR_W'(PAIRS - 1));
  assign abort_ev  = VSYNC & ((state_q == ST_FRAME) | (state_q == ST_DRAIN));
  assign done_ev   = (state_q == ST_DRAIN) & ~VSYNC & fifo_empty;
  assign pop       = mem.mem_we & mem.mem_ready;
  assign drop      = beat & fifo_full & ~pop;

  assign mem.mem_we                  = ~fifo_empty;
  assign {mem.mem_addr, mem.mem_wdata} = fifo_rdata;

  pair_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (ENTRY_W)
  ) u_fifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (beat),
    .pop    (pop),
    .flush  (abort_ev),
    .wdata  ({pair_q, DATA_1, DATA_0}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Frame state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame sequencing: VSYNC always re-arms once a frame is under way
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (VSYNC) state_d = ST_ARMED;
      ST_ARMED: if (!VSYNC) state_d = ST_FRAME;
      ST_FRAME: begin
        if (VSYNC)          state_d = ST_ARMED;
        else if (last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (VSYNC)           state_d = ST_ARMED;
        else if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE:  if (VSYNC) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Position tracking; the pair counter doubles as the write address
  always_ff @(posedge HCLK) begin
    if (HRESET || state_q == ST_ARMED) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
    end else if (beat) begin
      pair_q <= pair_q + ADDR_W'(1);
      if (col_q == COL_W'(WIDTH - 2)) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(2);
      end
    end
  end

  // Status: completion level, frame counter and sticky error flags
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      write_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_abort <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      write_done <= (state_d == ST_DONE);
      if (drop)     overflow    <= 1'b1;
      if (abort_ev) frame_abort <= 1'b1;
      if (done_ev)  frame_cnt   <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_depth_frame_writer.sv
// Bench for depth_frame_writer: two instances (FIFO depth 8 and 4) share the
// pixel stream and mem_ready; each has its own queue of required writes.
module tb_depth_frame_writer;
  import depth_pkg::*;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          VSYNC = 1'b0;
  logic          HSYNC = 1'b0;
  logic [DW-1:0] DATA_0 = '0;
  logic [DW-1:0] DATA_1 = '0;
  logic          mem_ready = 1'b1;
  logic          wd8, ovf8, ab8, wd4, ovf4, ab4;
  logic [7:0]    fc8, fc4;

  depth_frame_writer_if #(.ADDR_W(AW), .DW(DW)) m8 ();
  depth_frame_writer_if #(.ADDR_W(AW), .DW(DW)) m4 ();
  assign m8.mem_ready = mem_ready;
  assign m4.mem_ready = mem_ready;

  depth_frame_writer #(.WIDTH(W), .HEIGHT(H), .DW(DW), .ADDR_W(AW), .FIFO_DEPTH(8)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_0(DATA_0), .DATA_1(DATA_1), .mem(m8),
    .write_done(wd8), .overflow(ovf8), .frame_abort(ab8), .frame_cnt(fc8)
  );

  depth_frame_writer #(.WIDTH(W), .HEIGHT(H), .DW(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut4 (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_0(DATA_0), .DATA_1(DATA_1), .mem(m4),
    .write_done(wd4), .overflow(ovf4), .frame_abort(ab4), .frame_cnt(fc4)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] wdata;
  } wr_t;

  typedef struct {
    int       ready_low;   // beats 0..ready_low-1 see mem_ready=0
    int       base;        // DATA_0 of beat k is base+2k
    bit [7:0] drop8;       // beats the depth-8 instance must drop
    bit [7:0] drop4;       // beats the depth-4 instance must drop
    bit       ovf8;
    bit       ovf4;
  } vec_t;

  wr_t q8[$];
  wr_t q4[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Write monitors: an accepted write must match the head of its queue
  always @(negedge HCLK) begin
    wr_t e;
    if (HRESET === 1'b0 && m8.mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (q8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut8 extra write: addr %0h data %0h, no write required", m8.mem_addr, m8.mem_wdata);
      end else begin
        e = q8.pop_front();
        check("dut8 mem_addr", 32'(m8.mem_addr), 32'(e.addr));
        check("dut8 mem_wdata", 32'(m8.mem_wdata), 32'(e.wdata));
      end
    end
  end

  always @(negedge HCLK) begin
    wr_t e;
    if (HRESET === 1'b0 && m4.mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (q4.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut4 extra write: addr %0h data %0h, no write required", m4.mem_addr, m4.mem_wdata);
      end else begin
        e = q4.pop_front();
        check("dut4 mem_addr", 32'(m4.mem_addr), 32'(e.addr));
        check("dut4 mem_wdata", 32'(m4.mem_wdata), 32'(e.wdata));
      end
    end
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; mem_ready = 1'b1;
    cyc();
    HRESET = 1'b0;
    q8.delete();
    q4.delete();
  endtask

  // VSYNC high for three cycles, then one quiet cycle to enter the frame
  task automatic arm();
    HSYNC = 1'b0; VSYNC = 1'b1;
    repeat (3) cyc();
    VSYNC = 1'b0;
    cyc();
  endtask

  task automatic beat(input int k, input int base, input bit rdy, input bit dr8, input bit dr4);
    wr_t e;
    HSYNC = 1'b1;
    DATA_0 = 8'(base + 2*k);
    DATA_1 = 8'(base + 2*k + 1);
    mem_ready = rdy;
    e.addr  = 16'(k);
    e.wdata = {DATA_1, DATA_0};
    if (!dr8) q8.push_back(e);
    if (!dr4) q4.push_back(e);
    cyc();
    HSYNC = 1'b0;
  endtask

  task automatic full_frame(input int base);
    arm();
    for (int k = 0; k < 8; k++) beat(k, base, 1'b1, 1'b0, 1'b0);
  endtask

  // Bounded wait for both instances to report completion
  task automatic wait_done(input string nm);
    HSYNC = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (wd8 && wd4) break;
      cyc();
    end
    check({nm, " dut8 write_done"}, 32'(wd8), 32'd1);
    check({nm, " dut4 write_done"}, 32'(wd4), 32'd1);
    check({nm, " dut8 writes left"}, 32'(q8.size()), 32'd0);
    check({nm, " dut4 writes left"}, 32'(q4.size()), 32'd0);
  endtask

  task automatic stray(input string nm, input int n);
    VSYNC = 1'b0;
    for (int i = 0; i < n; i++) begin
      HSYNC = 1'b1; DATA_0 = 8'hEE; DATA_1 = 8'hDD;
      cyc();
      check({nm, " dut8 mem_we"}, 32'(m8.mem_we), 32'd0);
      check({nm, " dut4 mem_we"}, 32'(m4.mem_we), 32'd0);
    end
    HSYNC = 1'b0;
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{ready_low: 0, base: 8'h00, drop8: 8'h00, drop4: 8'h00, ovf8: 1'b0, ovf4: 1'b0};
    tbl[1] = '{ready_low: 8, base: 8'h20, drop8: 8'h00, drop4: 8'hF0, ovf8: 1'b0, ovf4: 1'b1};
    tbl[2] = '{ready_low: 6, base: 8'h40, drop8: 8'h00, drop4: 8'h30, ovf8: 1'b0, ovf4: 1'b1};

    // Clean frame, backpressure and overflow frames
    for (int t = 0; t < 3; t++) begin
      do_reset();
      check("reset mem_we", 32'(m8.mem_we), 32'd0);
      check("reset mem_addr", 32'(m8.mem_addr), 32'd0);
      check("reset mem_wdata", 32'(m8.mem_wdata), 32'd0);
      check("reset status", {ovf8, ab8, wd8, fc8, ovf4, ab4, wd4, fc4}, 32'd0);
      arm();
      for (int k = 0; k < 8; k++)
        beat(k, tbl[t].base, (k >= tbl[t].ready_low), tbl[t].drop8[k], tbl[t].drop4[k]);
      mem_ready = 1'b1;
      check("done before drain dut8", 32'(wd8), 32'd0);
      wait_done("table");
      check("table dut8 overflow", 32'(ovf8), 32'(tbl[t].ovf8));
      check("table dut4 overflow", 32'(ovf4), 32'(tbl[t].ovf4));
      check("table frame_abort", {ab8, ab4}, 32'd0);
      check("table dut8 frame_cnt", 32'(fc8), 32'd1);
      check("table dut4 frame_cnt", 32'(fc4), 32'd1);
    end

    // Abort: VSYNC (with a simultaneous beat) after beat 3, then a clean frame
    do_reset();
    arm();
    for (int k = 0; k < 4; k++) beat(k, 8'h60, 1'b1, 1'b0, 1'b0);
    VSYNC = 1'b1; HSYNC = 1'b1; DATA_0 = 8'h77; DATA_1 = 8'h66;
    cyc();
    HSYNC = 1'b0;
    check("abort dut8 mem_we", 32'(m8.mem_we), 32'd0);
    check("abort dut4 mem_we", 32'(m4.mem_we), 32'd0);
    check("abort flags", {ab8, ab4}, 32'd3);
    check("abort old writes left", 32'(q8.size() + q4.size()), 32'd0);
    full_frame(8'h80);
    wait_done("after abort");
    check("after abort frame_cnt", {fc8, fc4}, 32'h0101);
    check("after abort sticky", {ab8, ab4, ovf8, ovf4}, 32'hC);

    // Reset mid-frame after beat 2, strays in idle, then a clean frame
    do_reset();
    arm();
    for (int k = 0; k < 3; k++) beat(k, 8'hA0, 1'b1, 1'b0, 1'b0);
    HRESET = 1'b1;
    cyc();
    HRESET = 1'b0;
    q8.delete();
    q4.delete();
    check("midreset mem_we", {m8.mem_we, m4.mem_we}, 32'd0);
    check("midreset write_done", {wd8, wd4}, 32'd0);
    stray("idle stray", 3);
    full_frame(8'hC0);
    wait_done("after reset");
    check("after reset frame_cnt", {fc8, fc4}, 32'h0101);

    // Strays while done, then a second frame
    stray("done stray", 3);
    check("done stray write_done", {wd8, wd4}, 32'd3);
    check("done stray frame_cnt", {fc8, fc4}, 32'h0101);
    full_frame(8'hE0);
    wait_done("second frame");
    check("second frame frame_cnt", {fc8, fc4}, 32'h0202);
    check("second frame flags", {ab8, ab4, ovf8, ovf4}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
